tcm_arbiter: RTL and testbench

//  Two-master arbiter directly upstream of the TCM. Merges the instruction-fetch

---
 rtl/tcm_arbiter.sv | 121 ++++++++++++
 tb/tb_tcm_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcm_arbiter.sv
// tcm_arbiter: merges the instruction-fetch port and the data port onto the
// single TCM request bus and steers each TCM ack/read-data back to its issuer.
// The data port has priority. A starvation counter lets fetch win one contested
// cycle after STARVE_LIMIT consecutive losses.
module tcm_arbiter #(
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    // Instruction-fetch master (read-only)
    input  logic                        i_if_req,
    input  logic [MEM_ADDR_WIDTH+1:2]   i_if_addr,
    output logic                        o_if_gnt,
    output logic                        o_if_ack,
    output logic [31:0]                 o_if_data,
    // Data master (load/store)
    input  logic                        i_dm_req,
    input  logic [MEM_ADDR_WIDTH+1:2]   i_dm_addr,
    input  logic                        i_dm_write,
    input  logic [3:0]                  i_dm_sel,
    input  logic [31:0]                 i_dm_wdata,
    output logic                        o_dm_gnt,
    output logic                        o_dm_ack,
    output logic [31:0]                 o_dm_data,
    // TCM request bus
    output logic                        o_dev_sel,
    output logic [MEM_ADDR_WIDTH+1:2]   o_addr,
    output logic [3:0]                  o_sel,
    output logic                        o_write,
    output logic [31:0]                 o_wdata,
    input  logic                        i_ack,
    input  logic [31:0]                 i_rdata
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        WIN_NONE,
        WIN_IF,
        WIN_DM
    } winner_e;

    winner_e    winner;
    logic [3:0] r_starve;
    logic       r_vld;
    logic       r_own;

    // Pick this cycle's winner: data first unless fetch has waited long enough.
    always_comb begin
        // NOTE: default first so every path assigns winner; a missing branch would infer a latch.
        winner = WIN_NONE;
        if (i_if_req && i_dm_req) begin
            winner = (r_starve == STARVE_MAX) ? WIN_IF : WIN_DM;
        end else if (i_if_req) begin
            winner = WIN_IF;
        end else if (i_dm_req) begin
            winner = WIN_DM;
        end
    end

    // Drive grants and mux the winner onto the TCM bus; idle leaves the bus at zero.
    always_comb begin
        o_if_gnt  = 1'b0;
        o_dm_gnt  = 1'b0;
        o_dev_sel = 1'b0;
        o_addr    = '0;
        o_sel     = 4'h0;
        o_write   = 1'b0;
        o_wdata   = 32'h0;
        case (winner)
            WIN_IF: begin
                o_if_gnt  = 1'b1;
                o_dev_sel = 1'b1;
                o_addr    = i_if_addr;
                o_sel     = 4'hF;
            end
            WIN_DM: begin
                o_dm_gnt  = 1'b1;
                o_dev_sel = 1'b1;
                o_addr    = i_dm_addr;
                o_sel     = i_dm_sel;
                o_write   = i_dm_write;
                o_wdata   = i_dm_wdata;
            end
            default: ;
        endcase
    end

    // Count consecutive fetch losses, saturating at the limit.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_starve <= 4'd0;
        end else if (!i_if_req || o_if_gnt) begin
            // NOTE: non-blocking assignment for state so every flop samples pre-edge values.
            r_starve <= 4'd0;
        end else if (r_starve != STARVE_MAX) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    // Remember whether a request went out last cycle and which master owns it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_vld <= 1'b0;
            r_own <= 1'b0;
        end else begin
            r_vld <= o_dev_sel;
            r_own <= (winner == WIN_DM);
        end
    end

    // Steer the TCM response to its owner; a stray ack with no tag is dropped.
    always_comb begin
        o_if_ack  = i_ack & r_vld & ~r_own;
        o_dm_ack  = i_ack & r_vld & r_own;
        o_if_data = o_if_ack ? i_rdata : 32'h0;
        o_dm_data = o_dm_ack ? i_rdata : 32'h0;
    end

endmodule

// File: tb/tb_tcm_arbiter.sv
// tb_tcm_arbiter: random and directed stimulus for tcm_arbiter. A driver issues
// master requests and predicts grants/bus values from the arbitration rules; the
// expected response of each predicted access goes into a queue that a separate
// monitor drains whenever a response is due. A small TCM model answers requests.
module tb_tcm_arbiter;

    localparam int AW    = 8;
    localparam int LIMIT = 4;

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic          i_if_req;
    logic [AW+1:2] i_if_addr;
    logic          o_if_gnt, o_if_ack;
    logic [31:0]   o_if_data;
    logic          i_dm_req;
    logic [AW+1:2] i_dm_addr;
    logic          i_dm_write;
    logic [3:0]    i_dm_sel;
    logic [31:0]   i_dm_wdata;
    logic          o_dm_gnt, o_dm_ack;
    logic [31:0]   o_dm_data;
    logic          o_dev_sel;
    logic [AW+1:2] o_addr;
    logic [3:0]    o_sel;
    logic          o_write;
    logic [31:0]   o_wdata;
    logic          i_ack;
    logic [31:0]   i_rdata;

    always #5 i_clk = ~i_clk;

    tcm_arbiter #(.MEM_ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .o_if_gnt(o_if_gnt), .o_if_ack(o_if_ack), .o_if_data(o_if_data),
        .i_dm_req(i_dm_req), .i_dm_addr(i_dm_addr), .i_dm_write(i_dm_write),
        .i_dm_sel(i_dm_sel), .i_dm_wdata(i_dm_wdata),
        .o_dm_gnt(o_dm_gnt), .o_dm_ack(o_dm_ack), .o_dm_data(o_dm_data),
        .o_dev_sel(o_dev_sel), .o_addr(o_addr), .o_sel(o_sel), .o_write(o_write),
        .o_wdata(o_wdata), .i_ack(i_ack), .i_rdata(i_rdata)
    );

    typedef struct {
        bit          is_dm;
        bit          chk_data;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] tcm_mem[256];
    logic [31:0] gold[256];
    bit          force_ack = 1'b0;

    // Master-side request state (held until granted)
    bit          if_pend = 1'b0, dm_pend = 1'b0;
    logic [AW-1:0] if_a = '0, dm_a = '0;
    bit          dm_w = 1'b0;
    logic [3:0]  dm_s = '0;
    logic [31:0] dm_d = '0;
    bit          rst_val = 1'b0;
    int          losses = 0;
    bit          last_if_gnt;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // TCM model: samples the request bus mid-cycle, answers one cycle later.
    initial begin : tcm_model
        logic          s_sel, s_write;
        logic [AW+1:2] s_addr;
        logic [3:0]    s_be;
        logic [31:0]   s_wd;
        i_ack   = 1'b0;
        i_rdata = 32'h0;
        forever begin
            @(negedge i_clk);
            s_sel = o_dev_sel; s_write = o_write; s_addr = o_addr; s_be = o_sel; s_wd = o_wdata;
            @(posedge i_clk);
            #1;
            if (s_sel && s_write) tcm_mem[s_addr] = merge(tcm_mem[s_addr], s_wd, s_be);
            i_ack   = s_sel | force_ack;
            i_rdata = s_sel ? tcm_mem[s_addr] : $urandom;
        end
    end

    // One clock of stimulus plus prediction of grants and bus values.
    task automatic drive_cycle();
        bit          w_if, w_dm;
        exp_t        e;
        @(posedge i_clk);
        #1;
        i_reset_n = rst_val;
        if (!rst_val) exp_q.delete();
        i_if_req  = if_pend;  i_if_addr = if_a;
        i_dm_req  = dm_pend;  i_dm_addr = dm_a;
        i_dm_write = dm_w;    i_dm_sel = dm_s;  i_dm_wdata = dm_d;
        #3;
        w_if = if_pend && !(dm_pend && losses != LIMIT);
        w_dm = dm_pend && !w_if;
        check("if_gnt",  o_if_gnt,  w_if);
        check("dm_gnt",  o_dm_gnt,  w_dm);
        check("dev_sel", o_dev_sel, w_if | w_dm);
        check("addr",  o_addr,  w_if ? if_a : (w_dm ? dm_a : '0));
        check("sel",   o_sel,   w_if ? 4'hF : (w_dm ? dm_s : 4'h0));
        check("write", o_write, w_dm && dm_w);
        check("wdata", o_wdata, w_dm ? dm_d : 32'h0);
        if (rst_val && (w_if || w_dm)) begin
            e.is_dm    = w_dm;
            e.chk_data = w_if || !dm_w;
            e.data     = gold[w_if ? if_a : dm_a];
            e.cyc      = cyc;
            exp_q.push_back(e);
        end
        if (w_dm && dm_w) gold[dm_a] = merge(gold[dm_a], dm_d, dm_s);
        if (!rst_val || !if_pend || w_if) losses = 0;
        else if (losses < LIMIT) losses++;
        last_if_gnt = o_if_gnt;
        if (o_if_gnt) if_pend = 1'b0;
        if (o_dm_gnt) dm_pend = 1'b0;
    endtask

    // Monitor: compares master-side responses against the queued expectations.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge i_clk);
            #1;
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc - 1) begin
                void'(exp_q.pop_front());
                check("ack_missed", 32'd1, 32'd0);
            end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc - 1) begin
                e = exp_q.pop_front();
                check("if_ack", o_if_ack, !e.is_dm);
                check("dm_ack", o_dm_ack, e.is_dm);
                if (e.is_dm) begin
                    if (e.chk_data) check("dm_data", o_dm_data, e.data);
                    check("if_data_idle", o_if_data, 32'h0);
                end else begin
                    check("if_data", o_if_data, e.data);
                    check("dm_data_idle", o_dm_data, 32'h0);
                end
            end else begin
                check("stray_if_ack", o_if_ack, 1'b0);
                check("stray_dm_ack", o_dm_ack, 1'b0);
                check("if_data_zero", o_if_data, 32'h0);
                check("dm_data_zero", o_dm_data, 32'h0);
            end
        end
    end

    initial begin : main
        logic [7:0] gseq;
        int         first_if;
        logic [31:0] v;
        i_reset_n = 1'b0; i_if_req = 1'b0; i_if_addr = '0; i_dm_req = 1'b0;
        i_dm_addr = '0; i_dm_write = 1'b0; i_dm_sel = '0; i_dm_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            tcm_mem[i] = v;
            gold[i]    = v;
        end
        // Reset state with a stray ack forced high
        force_ack = 1'b1;
        repeat (3) drive_cycle();
        rst_val = 1'b1;
        drive_cycle();
        force_ack = 1'b0;

        // Fetch only, back to back at 0x10
        for (int i = 0; i < 3; i++) begin
            if_pend = 1'b1; if_a = 8'h10;
            drive_cycle();
        end

        // Partial store at 0x20 then load it back
        dm_pend = 1'b1; dm_a = 8'h20; dm_w = 1'b1; dm_s = 4'b0011; dm_d = 32'hDEADBEEF;
        drive_cycle();
        dm_pend = 1'b1; dm_w = 1'b0; dm_s = 4'hF; dm_d = 32'h0;
        drive_cycle();
        drive_cycle();
        check("store_low_half", gold[8'h20][15:0], 16'hBEEF);

        // Both masters held for 8 cycles: DM x4, IF, DM x3
        gseq = '0;
        for (int i = 0; i < 8; i++) begin
            if (!if_pend) begin if_pend = 1'b1; if_a = 8'(8'h30 + i); end
            if (!dm_pend) begin dm_pend = 1'b1; dm_a = 8'(8'h40 + i); dm_w = 1'b0; dm_s = 4'hF; end
            drive_cycle();
            gseq[i] = last_if_gnt;
        end
        check("starve_sequence", gseq, 8'b0001_0000);
        if_pend = 1'b0; dm_pend = 1'b0;
        drive_cycle();

        // Alternating single-master requests
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin if_pend = 1'b1; if_a = 8'(i); end
            else begin dm_pend = 1'b1; dm_a = 8'(i); dm_w = 1'b0; dm_s = 4'hF; end
            drive_cycle();
        end

        // Reset in the cycle after a contested grant, with ack forced high
        for (int i = 0; i < 2; i++) begin
            if_pend = 1'b1; if_a = 8'h50;
            dm_pend = 1'b1; dm_a = 8'h51; dm_w = 1'b0; dm_s = 4'hF;
            drive_cycle();
        end
        rst_val = 1'b0; if_pend = 1'b0; dm_pend = 1'b0; force_ack = 1'b1;
        drive_cycle();
        rst_val = 1'b1; force_ack = 1'b0;
        first_if = -1;
        for (int i = 0; i < 6; i++) begin
            if (!if_pend) begin if_pend = 1'b1; if_a = 8'h52; end
            if (!dm_pend) begin dm_pend = 1'b1; dm_a = 8'h53; dm_w = 1'b0; dm_s = 4'hF; end
            drive_cycle();
            if (last_if_gnt && first_if < 0) first_if = i;
        end
        check("starve_after_reset", first_if, 4);
        if_pend = 1'b0; dm_pend = 1'b0;

        // Idle with ack forced high
        force_ack = 1'b1;
        repeat (4) drive_cycle();
        force_ack = 1'b0;

        // Random traffic over a small address window
        for (int n = 0; n < 400; n++) begin
            if (!if_pend && $urandom_range(0, 3) != 0) begin
                if_pend = 1'b1; if_a = 8'($urandom_range(0, 15));
            end
            if (!dm_pend && $urandom_range(0, 2) != 0) begin
                dm_pend = 1'b1; dm_a = 8'($urandom_range(0, 15));
                dm_w = 1'($urandom_range(0, 1)); dm_s = 4'($urandom); dm_d = $urandom;
            end
            force_ack = ($urandom_range(0, 3) == 0);
            drive_cycle();
        end
        force_ack = 1'b0; if_pend = 1'b0; dm_pend = 1'b0;
        repeat (3) drive_cycle();
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
